// File: rtl/crypto1_pkg.sv
// Shared Crypto1 math: LFSR feedback taps, filter tables and the helper
// functions used by both the forward keystream generator and the crackers.
package crypto1_pkg;

    // Taps 0,5,9,10,12,14,15,17,19,24,25,27,29,35,39,41,42,43
    localparam logic [47:0] FB_MASK = 48'h0E882B0AD621;
    localparam logic [15:0] TA      = 16'hF22C;
    localparam logic [15:0] TB      = 16'hD938;
    localparam logic [31:0] TC      = 32'hEC57E80A;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RUN,
        ST_HOLD
    } ks_state_e;

    function automatic logic crypto1_feedback(input logic [47:0] s);
        return ^(s & FB_MASK);
    endfunction

    // Two-layer nonlinear filter over the odd state bits 9..47
    function automatic logic crypto1_filter_f(input logic [47:0] s);
        logic [4:0] g;
        g[4] = TA[{s[41], s[43], s[45], s[47]}];
        g[3] = TB[{s[33], s[35], s[37], s[39]}];
        g[2] = TA[{s[25], s[27], s[29], s[31]}];
        g[1] = TA[{s[17], s[19], s[21], s[23]}];
        g[0] = TB[{s[9],  s[11], s[13], s[15]}];
        return TC[g];
    endfunction

endpackage

// File: rtl/crypto1_filter.sv
// Combinational Crypto1 output filter: 48-bit LFSR state in, keystream bit out.
module crypto1_filter
    import crypto1_pkg::*;
(
    input  logic [47:0] state_i,
    output logic        f_o
);

    assign f_o = crypto1_filter_f(state_i);

endmodule

// File: rtl/crypto1_keystream.sv
// Forward Crypto1 keystream generator: loads a key, clocks the LFSR NBITS
// times with optional feed injection, and returns the keystream word.
module crypto1_keystream
    import crypto1_pkg::*;
#(
    parameter int NBITS = 48
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [47:0]      key_i,
    input  logic [NBITS-1:0] feed_i,
    input  logic             feed_en_i,
    output logic             busy_o,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [NBITS-1:0] bitstream_o,
    output logic [47:0]      state_o
);

    localparam int CW = $clog2(NBITS + 1);

    ks_state_e        state_q;
    logic [47:0]      key_q;
    logic [47:0]      s_q, s_d;
    logic [NBITS-1:0] feed_q, feed_d;
    logic [NBITS-1:0] ks_q, ks_d;
    logic [NBITS-1:0] bits_q;
    logic [47:0]      st_out_q;
    logic             feed_en_q;
    logic             busy_q;
    logic             valid_q;
    logic [CW-1:0]    cnt_q;
    logic             f_bit;

    crypto1_filter u_filter (
        .state_i (s_q),
        .f_o     (f_bit)
    );

    // feed_q and ks_q are shift registers, so step i always sees feed bit i
    // and the bit produced at step i settles in position i after NBITS steps.
    always_comb begin
        s_d    = {crypto1_feedback(s_q) ^ (feed_en_q & feed_q[0]), s_q[47:1]};
        feed_d = feed_q >> 1;
        ks_d   = (ks_q >> 1) | (NBITS'(f_bit) << (NBITS - 1));
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            key_q     <= '0;
            s_q       <= '0;
            feed_q    <= '0;
            ks_q      <= '0;
            bits_q    <= '0;
            st_out_q  <= '0;
            feed_en_q <= 1'b0;
            busy_q    <= 1'b0;
            valid_q   <= 1'b0;
            cnt_q     <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        key_q     <= key_i;
                        feed_q    <= feed_i;
                        feed_en_q <= feed_en_i;
                        busy_q    <= 1'b1;
                        cnt_q     <= '0;
                        state_q   <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    s_q     <= key_q;
                    ks_q    <= '0;
                    state_q <= ST_RUN;
                end
                ST_RUN: begin
                    s_q    <= s_d;
                    feed_q <= feed_d;
                    ks_q   <= ks_d;
                    cnt_q  <= cnt_q + CW'(1);
                    if (cnt_q == CW'(NBITS - 1)) begin
                        state_q <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    // First HOLD cycle publishes the result; outputs then stay
                    // frozen until the consumer takes it.
                    if (!valid_q) begin
                        valid_q  <= 1'b1;
                        bits_q   <= ks_q;
                        st_out_q <= s_q;
                    end else if (ready_i) begin
                        valid_q <= 1'b0;
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign busy_o      = busy_q;
    assign valid_o     = valid_q;
    assign bitstream_o = bits_q;
    assign state_o     = st_out_q;

endmodule

// File: doc/crypto1_keystream.md
# crypto1_keystream

Forward Crypto1 keystream generator: loads a 48-bit key into the Crypto1 LFSR, optionally XORs an input bitstream into the feedback, and emits NBITS keystream bits as one parallel word. It is the forward counterpart to the key-recovery cores. It produces the BITSTREAM those cores consume, and it re-checks a recovered KEY against a captured keystream. It sits beside the cracker array in the top level, driven by the host/controller over a start/valid/ready handshake.

## Interface
- NBITS, 48: keystream bits generated per run (1..64).
- CLK  in  1  clock, rising edge.
- RESET  in  1  asynchronous, active-high reset.
- START  in  1  request a run; accepted only in IDLE.
- KEY  in  48  key; KEY[i] loads state bit s[i]; sampled on accepted START.
- FEED  in  NBITS  bit i XORed into feedback at step i when FEED_EN; sampled on accepted START.
- FEED_EN  in  1  enable FEED injection; sampled on accepted START.
- BUSY  out  1  high from accepted START until the result is consumed.
- VALID  out  1  result available.
- READY  in  1  consumer accepts result when VALID & READY.
- BITSTREAM  out  NBITS  BITSTREAM[i] = keystream bit of step i.
- STATE  out  48  LFSR state after the last step.

## Operation
- State s[47:0]. Each step i, in order:
  - Output: BITSTREAM[i] = f(s).
  - Shift: s <= {L(s) ^ (FEED_EN & FEED[i]), s[47:1]}.
- Feedback L = XOR of s[0,5,9,10,12,14,15,17,19,24,25,27,29,35,39,41,42,43].
- Filter f, using 4-bit indices written MSB first:
  - g0 = TA[{s41,s43,s45,s47}]
  - g1 = TB[{s33,s35,s37,s39}]
  - g2 = TA[{s25,s27,s29,s31}]
  - g3 = TA[{s17,s19,s21,s23}]
  - g4 = TB[{s9,s11,s13,s15}]
  - f = TC[{g0,g1,g2,g3,g4}]
  - TA=16'hF22C, TB=16'hD938, TC=32'hEC57E80A; T[n] is bit n.
- FSM states:
  - IDLE: START -> LOAD. Registers KEY, FEED, FEED_EN; sets BUSY; clears the step counter.
  - LOAD: s <= KEY -> RUN.
  - RUN: one step per cycle. Step counter cnt, width clog2(NBITS+1). cnt == NBITS-1 -> HOLD, with VALID set the following cycle.
  - HOLD: VALID high. VALID & READY -> IDLE, clearing VALID and BUSY.
- START is ignored outside IDLE.
- A new START is accepted in the IDLE cycle after the handshake; no back-to-back overlap.
- BITSTREAM and STATE are stable while VALID is high. They keep their last value in IDLE.

## Timing
- Reset values: state IDLE; BUSY=0; VALID=0; BITSTREAM=0; STATE=0; internal s=0; cnt=0.
- RESET asserted mid-run aborts immediately to the reset values. No partial VALID is produced.
- Latency: START accepted at edge t -> LOAD at t+1 -> RUN steps at t+2 .. t+1+NBITS -> VALID at t+2+NBITS.
- VALID and READY high on the same edge: consume, VALID=0 next cycle.
- READY high while VALID=0: no effect.
- READY held high continuously: VALID is high for exactly one cycle.
- START high during the consuming cycle: ignored. The block is still in HOLD.
- NBITS=1: VALID at t+3.

## Structure
- crypto1_pkg holds:
  - tap list / feedback mask 48'h... from the tap set;
  - TA, TB, TC constants;
  - functions crypto1_filter_f and crypto1_feedback.
- The cracker cores use the same package, so forward and reverse use identical math.
- One sub-module, crypto1_filter: combinational 48-bit state -> 1 bit. It is shared with the key-recovery datapath.

## Test plan
- KEY=0, FEED_EN=0, NBITS=48, START -> VALID at t+50; BITSTREAM=48'h0, STATE=48'h0.
- KEY=48'hFFFFFFFFFFFF, FEED_EN=0 -> BITSTREAM[0]=1; L(all ones)=0, so STATE[47]=0 after the first shift. Full word matches the crapto1 C model.
- 1000 random KEY/FEED vectors, FEED_EN random -> BITSTREAM and STATE bit-exact against the crapto1 C model via DPI.
- Handshake:
  - READY held low 20 cycles after VALID -> outputs stable, BUSY=1.
  - Second START during RUN and HOLD -> ignored.
  - READY pulse -> VALID=0 next cycle.
- RESET asserted at step 17 of a run -> all outputs 0 on the next edge; a fresh START then yields the correct result.
- Round trip: key from a Crypto1 cracker core run on a generated BITSTREAM -> regenerated BITSTREAM equals the original.
